bin2bcd_seq: RTL

Parametrised sequential binary-to-decimal converter using double-dabble (shift-and-add-3), one bit per clock. It is the successor to the fixed 16-bit/5-digit successive-subtraction converter. It adds:
- configurable width and digit count
- start/busy/done handshake
- optional signed input
- leading-zero blank mask
- overflow saturation

It sits between the keypad bit register and the LCD driver, feeding digit codes and blank flags.

---
 rtl/bin2bcd_pkg.sv | 21 ++
 rtl/bin2bcd_seq_add3.sv | 9 +
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and elaboration helpers for the sequential double-dabble converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StFinish = 2'd2
  } state_t;

  localparam logic [3:0] NINE = 4'd9;

  // Decimal digits needed for a width-bit unsigned value: ceil(width * log10(2)).
  function automatic int unsigned min_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit when it is 5 or more.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, with sign handling,
// leading-zero blank mask and saturation on overflow.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  overflow
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_t                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [WIDTH-1:0]      mag_q;
  logic [4*DIGITS-1:0]   work_q;
  logic                  sign_q;
  logic                  ovf_q;

  logic [WIDTH-1:0]      mag_in;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   final_bcd;
  logic [DIGITS-1:0]     blank_next;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (work_q[4*i +: 4]),
      .adjusted (adj[4*i +: 4])
    );
  end

  // Unsigned WIDTH-bit negate, so the most negative input maps to 2^(WIDTH-1).
  always_comb begin
    mag_in = bin_in;
    if (is_signed && bin_in[WIDTH-1]) begin
      mag_in = ~bin_in + WIDTH'(1);
    end
  end

  always_comb begin
    logic zero_above;
    final_bcd  = ovf_q ? {DIGITS{NINE}} : work_q;
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (final_bcd[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mag_q      <= '0;
      work_q     <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      negative   <= 1'b0;
      blank_mask <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mag_q   <= mag_in;
            sign_q  <= is_signed & bin_in[WIDTH-1];
            work_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CntW'(WIDTH);
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          work_q <= {adj[4*DIGITS-2:0], mag_q[WIDTH-1]};
          mag_q  <= {mag_q[WIDTH-2:0], 1'b0};
          // A bit leaving the top digit means the value needs more than DIGITS digits.
          ovf_q  <= ovf_q | adj[4*DIGITS-1];
          cnt_q  <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          bcd_out    <= final_bcd;
          negative   <= sign_q;
          overflow   <= ovf_q;
          blank_mask <= blank_next;
          done       <= 1'b1;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
